// File: rtl/uart_prog_loader.sv
// uart_prog_loader: turns the UART RX byte stream into instruction-memory
// writes. A frame has a 4-byte little-endian word count N, then N*4 data bytes
// (each word LSB first), then one checksum byte. The checksum is the 8-bit sum
// of the data bytes only. The core is held for the whole frame. The block
// reports either load_done or load_err, each as a one-cycle pulse.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for the first length byte of a frame
// LEN    | collecting length bytes 1..3
// DATA   | collecting data bytes; one memory write per completed word
// CSUM   | waiting for the checksum byte
// ERR    | one-cycle error state; a byte arriving here starts a new frame
module uart_prog_loader #(
   parameter int ADDR_WIDTH     = 12,
   parameter int BASE_ADDR      = 0,
   parameter int MAX_WORDS      = 1024,
   parameter int TIMEOUT_CYCLES = 4_000_000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  io_data_valid,
   input  logic [7:0]            io_data_packet,
   output logic                  mem_wr_en,
   output logic [ADDR_WIDTH-1:0] mem_wr_addr,
   output logic [31:0]           mem_wr_data,
   output logic                  cpu_hold,
   output logic                  load_done,
   output logic                  load_err,
   output logic                  err_sticky
);

   localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN,
      S_DATA,
      S_CSUM,
      S_ERR
   } state_t;

   state_t           state;
   logic [31:0]      len;
   logic [31:0]      word;
   logic [31:0]      word_idx;
   logic [1:0]       byte_idx;
   logic [7:0]       sum;
   logic [TMO_W-1:0] tmo_cnt;

   logic [31:0]           len_full;
   logic [31:0]           word_full;
   logic [ADDR_WIDTH-1:0] wr_addr_next;
   logic                  in_frame;
   logic                  tmo_expire;

   // Bytes are shifted in from the top, so after four bytes the first one sits
   // in [7:0]. These give the completed value in the cycle of the final byte.
   assign len_full     = {io_data_packet, len[31:8]};
   assign word_full    = {io_data_packet, word[31:8]};
   assign wr_addr_next = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'({word_idx, 2'b00});

   // Timeout: the counter reads c-1 in the c-th silent cycle. An expiry decided
   // at count TIMEOUT_CYCLES-2 therefore puts load_err exactly TIMEOUT_CYCLES
   // cycles after the last byte. A byte in that same cycle suppresses the expiry.
   assign in_frame   = (state == S_LEN) || (state == S_DATA) || (state == S_CSUM);
   assign tmo_expire = in_frame && !io_data_valid &&
                       (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 2));

   // Frame decoder, datapath accumulators and all registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         len         <= '0;
         word        <= '0;
         word_idx    <= '0;
         byte_idx    <= '0;
         sum         <= '0;
         tmo_cnt     <= '0;
         mem_wr_en   <= 1'b0;
         mem_wr_addr <= '0;
         mem_wr_data <= '0;
         cpu_hold    <= 1'b0;
         load_done   <= 1'b0;
         load_err    <= 1'b0;
         err_sticky  <= 1'b0;
      end else begin
         mem_wr_en <= 1'b0;
         load_done <= 1'b0;
         load_err  <= 1'b0;

         if (!in_frame || io_data_valid) begin
            tmo_cnt <= '0;
         end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
         end

         case (state)
            S_IDLE, S_ERR: begin
               if (io_data_valid) begin
                  len        <= {io_data_packet, 24'h0};
                  byte_idx   <= 2'd1;
                  cpu_hold   <= 1'b1;
                  err_sticky <= 1'b0;
                  sum        <= '0;
                  state      <= S_LEN;
               end else begin
                  state <= S_IDLE;
               end
            end

            S_LEN: begin
               if (io_data_valid) begin
                  len      <= len_full;
                  byte_idx <= byte_idx + 2'd1;
                  if (byte_idx == 2'd3) begin
                     if (len_full == 32'd0) begin
                        state <= S_CSUM;
                     end else if (len_full > 32'(MAX_WORDS)) begin
                        load_err   <= 1'b1;
                        err_sticky <= 1'b1;
                        cpu_hold   <= 1'b0;
                        state      <= S_ERR;
                     end else begin
                        word_idx <= '0;
                        byte_idx <= 2'd0;
                        state    <= S_DATA;
                     end
                  end
               end else if (tmo_expire) begin
                  load_err   <= 1'b1;
                  err_sticky <= 1'b1;
                  cpu_hold   <= 1'b0;
                  state      <= S_ERR;
               end
            end

            S_DATA: begin
               if (io_data_valid) begin
                  word     <= word_full;
                  sum      <= sum + io_data_packet;
                  byte_idx <= byte_idx + 2'd1;
                  if (byte_idx == 2'd3) begin
                     mem_wr_en   <= 1'b1;
                     mem_wr_addr <= wr_addr_next;
                     mem_wr_data <= word_full;
                     word_idx    <= word_idx + 32'd1;
                     if (word_idx == len - 32'd1) begin
                        state <= S_CSUM;
                     end
                  end
               end else if (tmo_expire) begin
                  load_err   <= 1'b1;
                  err_sticky <= 1'b1;
                  cpu_hold   <= 1'b0;
                  state      <= S_ERR;
               end
            end

            S_CSUM: begin
               if (io_data_valid) begin
                  cpu_hold <= 1'b0;
                  if (io_data_packet == sum) begin
                     load_done <= 1'b1;
                     state     <= S_IDLE;
                  end else begin
                     load_err   <= 1'b1;
                     err_sticky <= 1'b1;
                     state      <= S_ERR;
                  end
               end else if (tmo_expire) begin
                  load_err   <= 1'b1;
                  err_sticky <= 1'b1;
                  cpu_hold   <= 1'b0;
                  state      <= S_ERR;
               end
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed bench for uart_prog_loader. It uses a 100-cycle timeout and base
// address 0x100. Bytes are driven just after a rising edge. Each byte's effect
// is checked just after the following edge.
module tb_uart_prog_loader;

   localparam int AW = 12;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          io_data_valid = 1'b0;
   logic [7:0]    io_data_packet = 8'h00;
   logic          mem_wr_en;
   logic [AW-1:0] mem_wr_addr;
   logic [31:0]   mem_wr_data;
   logic          cpu_hold;
   logic          load_done;
   logic          load_err;
   logic          err_sticky;

   int checks = 0;
   int errors = 0;
   int wr_count = 0;
   int done_count = 0;
   int err_count = 0;

   uart_prog_loader #(
      .ADDR_WIDTH(AW),
      .BASE_ADDR(32'h100),
      .MAX_WORDS(1024),
      .TIMEOUT_CYCLES(100)
   ) dut (
      .clk(clk),
      .reset(reset),
      .io_data_valid(io_data_valid),
      .io_data_packet(io_data_packet),
      .mem_wr_en(mem_wr_en),
      .mem_wr_addr(mem_wr_addr),
      .mem_wr_data(mem_wr_data),
      .cpu_hold(cpu_hold),
      .load_done(load_done),
      .load_err(load_err),
      .err_sticky(err_sticky)
   );

   always #5 clk = ~clk;

   // Pulse counters sampled on the falling edge.
   always @(negedge clk) begin
      if (mem_wr_en) wr_count++;
      if (load_done) done_count++;
      if (load_err)  err_count++;
   end

   task automatic send_byte(input logic [7:0] b);
      io_data_valid  = 1'b1;
      io_data_packet = b;
      @(posedge clk);
      #1;
      io_data_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      idle(2);
      reset = 1'b0;
      checks++; if (mem_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b expected 0", mem_wr_en); end
      checks++; if (mem_wr_addr !== 12'h000) begin errors++; $display("FAIL reset_addr: got %h expected 000", mem_wr_addr); end
      checks++; if (mem_wr_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", mem_wr_data); end
      checks++; if ({cpu_hold, load_done, load_err, err_sticky} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b expected 0000", {cpu_hold, load_done, load_err, err_sticky}); end
   endtask

   task automatic test_normal_load;
      int w0, e0;
      w0 = wr_count; e0 = err_count;
      send_byte(8'h02);
      checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL normal_hold: got %b expected 1", cpu_hold); end
      send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
      send_byte(8'h78); send_byte(8'h56); send_byte(8'h34);
      checks++; if (mem_wr_en !== 1'b0) begin errors++; $display("FAIL normal_early_wr: got %b expected 0", mem_wr_en); end
      send_byte(8'h12);
      checks++; if ({mem_wr_en, mem_wr_addr, mem_wr_data} !== {1'b1, 12'h100, 32'h12345678}) begin errors++; $display("FAIL normal_wr0: got %b %h %h expected 1 100 12345678", mem_wr_en, mem_wr_addr, mem_wr_data); end
      send_byte(8'hEF);
      checks++; if ({mem_wr_en, mem_wr_addr, mem_wr_data} !== {1'b0, 12'h100, 32'h12345678}) begin errors++; $display("FAIL normal_hold_addr: got %b %h %h expected 0 100 12345678", mem_wr_en, mem_wr_addr, mem_wr_data); end
      send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
      checks++; if ({mem_wr_en, mem_wr_addr, mem_wr_data} !== {1'b1, 12'h104, 32'hDEADBEEF}) begin errors++; $display("FAIL normal_wr1: got %b %h %h expected 1 104 deadbeef", mem_wr_en, mem_wr_addr, mem_wr_data); end
      send_byte(8'h4C);
      checks++; if ({load_done, cpu_hold, load_err} !== 3'b100) begin errors++; $display("FAIL normal_done: got done/hold/err %b expected 100", {load_done, cpu_hold, load_err}); end
      idle(1);
      checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL normal_done_pulse: got %b expected 0", load_done); end
      checks++; if (wr_count - w0 !== 2) begin errors++; $display("FAIL normal_wr_count: got %0d expected 2", wr_count - w0); end
      checks++; if (err_count - e0 !== 0) begin errors++; $display("FAIL normal_no_err: got %0d expected 0", err_count - e0); end
   endtask

   task automatic test_bad_checksum;
      int w0, d0;
      logic [7:0] fr [13] = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                              8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h4D};
      w0 = wr_count; d0 = done_count;
      for (int i = 0; i < 13; i++) send_byte(fr[i]);
      checks++; if ({load_err, err_sticky, load_done, cpu_hold} !== 4'b1100) begin errors++; $display("FAIL badsum_flags: got err/sticky/done/hold %b expected 1100", {load_err, err_sticky, load_done, cpu_hold}); end
      idle(1);
      checks++; if ({load_err, err_sticky} !== 2'b01) begin errors++; $display("FAIL badsum_sticky: got err/sticky %b expected 01", {load_err, err_sticky}); end
      checks++; if (wr_count - w0 !== 2 || done_count - d0 !== 0) begin errors++; $display("FAIL badsum_counts: got wr %0d done %0d expected 2 0", wr_count - w0, done_count - d0); end
   endtask

   task automatic test_empty_frame;
      int w0;
      w0 = wr_count;
      send_byte(8'h00);
      checks++; if (err_sticky !== 1'b0) begin errors++; $display("FAIL empty_sticky_clear: got %b expected 0", err_sticky); end
      send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
      checks++; if ({load_done, load_err, cpu_hold} !== 3'b100) begin errors++; $display("FAIL empty_done: got done/err/hold %b expected 100", {load_done, load_err, cpu_hold}); end
      send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
      checks++; if ({load_done, load_err} !== 2'b01) begin errors++; $display("FAIL empty_badsum: got done/err %b expected 01", {load_done, load_err}); end
      checks++; if (wr_count - w0 !== 0) begin errors++; $display("FAIL empty_no_wr: got %0d expected 0", wr_count - w0); end
   endtask

   task automatic test_len_overflow;
      int w0;
      w0 = wr_count;
      send_byte(8'h01); send_byte(8'h04); send_byte(8'h00);
      checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL ovf_early_err: got %b expected 0", load_err); end
      send_byte(8'h00);
      checks++; if ({load_err, err_sticky, cpu_hold} !== 3'b110) begin errors++; $display("FAIL ovf_err: got err/sticky/hold %b expected 110", {load_err, err_sticky, cpu_hold}); end
      idle(3);
      checks++; if (wr_count - w0 !== 0) begin errors++; $display("FAIL ovf_no_wr: got %0d expected 0", wr_count - w0); end
      send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
      send_byte(8'h04); send_byte(8'h03); send_byte(8'h02); send_byte(8'h01);
      checks++; if ({mem_wr_en, mem_wr_addr, mem_wr_data} !== {1'b1, 12'h100, 32'h01020304}) begin errors++; $display("FAIL ovf_next_wr: got %b %h %h expected 1 100 01020304", mem_wr_en, mem_wr_addr, mem_wr_data); end
      send_byte(8'h0A);
      checks++; if ({load_done, load_err} !== 2'b10) begin errors++; $display("FAIL ovf_next_done: got done/err %b expected 10", {load_done, load_err}); end
   endtask

   task automatic test_timeout;
      int e0;
      send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
      idle(98);
      checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL tmo_early: got %b expected 0 at cycle 99", load_err); end
      idle(1);
      checks++; if ({load_err, err_sticky, cpu_hold} !== 3'b110) begin errors++; $display("FAIL tmo_expire: got err/sticky/hold %b expected 110 at cycle 100", {load_err, err_sticky, cpu_hold}); end
      idle(2);
      e0 = err_count;
      send_byte(8'h00);
      checks++; if (err_sticky !== 1'b0) begin errors++; $display("FAIL tmo_sticky_clear: got %b expected 0", err_sticky); end
      send_byte(8'h00); send_byte(8'h00);
      idle(98);
      send_byte(8'h00);
      checks++; if ({load_err, cpu_hold} !== 2'b01) begin errors++; $display("FAIL tmo_byte_wins: got err/hold %b expected 01", {load_err, cpu_hold}); end
      send_byte(8'h00);
      checks++; if ({load_done, load_err} !== 2'b10) begin errors++; $display("FAIL tmo_frame_done: got done/err %b expected 10", {load_done, load_err}); end
      checks++; if (err_count - e0 !== 0) begin errors++; $display("FAIL tmo_no_err: got %0d expected 0", err_count - e0); end
   endtask

   task automatic test_back_to_back;
      int w0;
      logic [7:0] fr [17] = '{8'h03, 8'h00, 8'h00, 8'h00,
                              8'h11, 8'h22, 8'h33, 8'h44,
                              8'h55, 8'h66, 8'h77, 8'h88,
                              8'h99, 8'hAA, 8'hBB, 8'hCC, 8'h2E};
      logic [11:0] exp_addr [3] = '{12'h100, 12'h104, 12'h108};
      logic [31:0] exp_data [3] = '{32'h44332211, 32'h88776655, 32'hCCBBAA99};
      w0 = wr_count;
      for (int i = 0; i < 17; i++) begin
         send_byte(fr[i]);
         if (i == 7 || i == 11 || i == 15) begin
            checks++;
            if ({mem_wr_en, mem_wr_addr, mem_wr_data} !== {1'b1, exp_addr[(i-7)/4], exp_data[(i-7)/4]}) begin
               errors++;
               $display("FAIL b2b_wr%0d: got %b %h %h expected 1 %h %h", (i-7)/4, mem_wr_en, mem_wr_addr, mem_wr_data, exp_addr[(i-7)/4], exp_data[(i-7)/4]);
            end
         end
      end
      checks++; if ({load_done, load_err, cpu_hold} !== 3'b100) begin errors++; $display("FAIL b2b_done: got done/err/hold %b expected 100", {load_done, load_err, cpu_hold}); end
      checks++; if (wr_count - w0 !== 3) begin errors++; $display("FAIL b2b_wr_count: got %0d expected 3", wr_count - w0); end
   endtask

   task automatic test_reset_mid;
      logic [7:0] fr [8] = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
      for (int i = 0; i < 8; i++) send_byte(fr[i]);
      send_byte(8'h05); send_byte(8'h06);
      reset = 1'b1;
      idle(1);
      reset = 1'b0;
      checks++; if ({mem_wr_en, mem_wr_addr, mem_wr_data} !== {1'b0, 12'h000, 32'h0}) begin errors++; $display("FAIL rst_mid_mem: got %b %h %h expected 0 000 0", mem_wr_en, mem_wr_addr, mem_wr_data); end
      checks++; if ({cpu_hold, load_done, load_err, err_sticky} !== 4'b0000) begin errors++; $display("FAIL rst_mid_flags: got %b expected 0000", {cpu_hold, load_done, load_err, err_sticky}); end
      send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
      send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
      checks++; if ({mem_wr_en, mem_wr_addr, mem_wr_data} !== {1'b1, 12'h100, 32'hDDCCBBAA}) begin errors++; $display("FAIL rst_mid_wr: got %b %h %h expected 1 100 ddccbbaa", mem_wr_en, mem_wr_addr, mem_wr_data); end
      send_byte(8'h0E);
      checks++; if ({load_done, load_err} !== 2'b10) begin errors++; $display("FAIL rst_mid_done: got done/err %b expected 10", {load_done, load_err}); end
   endtask

   initial begin
      #1;
      test_reset();
      test_normal_load();
      test_bad_checksum();
      test_empty_frame();
      test_len_overflow();
      test_timeout();
      test_back_to_back();
      test_reset_mid();
      idle(2);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_prog_loader.md
Name: uart_prog_loader

Overview:
Consumes the byte stream from the UART receiver (one-cycle valid strobe plus 8-bit packet) and decodes a framed program image. It assembles the data bytes into 32-bit little-endian words and writes them sequentially into instruction memory. It holds the CPU while loading and reports completion or error. It sits between the UART RX stage and the instruction-memory write port of the 5-stage core.

Parameters:
ADDR_WIDTH, 12, width of the byte address on mem_wr_addr.
BASE_ADDR, 0, byte address of the first word written; must be 4-aligned.
MAX_WORDS, 1024, largest accepted word count; larger counts are a length error.
TIMEOUT_CYCLES, 4_000_000, idle cycles allowed between bytes inside a frame (100 ms at 40 MHz).

Ports:
clk  in  1  system clock; all logic on the rising edge.
reset  in  1  synchronous, active-high reset.
io_data_valid  in  1  one-cycle strobe: io_data_packet holds a received byte.
io_data_packet  in  8  received byte.
mem_wr_en  out  1  one-cycle instruction-memory write strobe.
mem_wr_addr  out  ADDR_WIDTH  byte address of the write; always 4-aligned.
mem_wr_data  out  32  word to write.
cpu_hold  out  1  high while a frame is in progress; keeps the core stalled/reset.
load_done  out  1  one-cycle pulse: frame accepted and checksum matched.
load_err  out  1  one-cycle pulse: frame aborted (checksum, length or timeout).
err_sticky  out  1  set with load_err; cleared by reset or by the first byte of the next frame.

Behaviour:
- Frame format:
  - 4 length bytes: word count N, 32-bit little-endian.
  - N×4 data bytes: each word little-endian, LSB first.
  - 1 checksum byte: 8-bit modulo-256 sum of all data bytes; the length bytes are excluded.
- Reset: state IDLE. All outputs are 0, and all counters, accumulators and the sum are cleared.
- All outputs are registered. A byte takes effect in the cycle its valid is high; any resulting pulse appears on the following cycle.
- The block accepts io_data_valid on consecutive cycles with no bubbles. It never stalls the RX stage, which has no ready signal.
- States:
  - IDLE: a byte arrives → it is taken as length byte 0; byte_idx=1; cpu_hold=1; err_sticky=0; sum=0; go LEN.
  - LEN: each byte is shifted into len[31:0] at position byte_idx. After byte 3, evaluate the completed length:
    - N==0 → CSUM.
    - N>MAX_WORDS → ERR.
    - Otherwise → DATA with word_idx=0, byte_idx=0.
  - DATA: each byte is shifted into word <= {byte, word[31:8]} and added to sum (8-bit wrap). On the 4th byte of a word:
    - Next cycle: mem_wr_en=1, mem_wr_addr=BASE_ADDR+4*word_idx (truncated to ADDR_WIDTH), mem_wr_data=assembled word.
    - word_idx increments.
    - If this was word N-1 → CSUM; otherwise stay in DATA.
  - CSUM: the next byte is compared with sum.
    - Equal → next cycle load_done=1, cpu_hold=0, go IDLE.
    - Unequal → ERR.
  - ERR (one cycle): load_err=1, err_sticky=1, cpu_hold=0, go IDLE.
- Timeout:
  - Applies in LEN, DATA and CSUM.
  - Counter clears on each valid byte and increments each cycle without one.
  - When it reaches TIMEOUT_CYCLES-1 with no valid byte, go ERR. load_err is therefore high exactly TIMEOUT_CYCLES cycles after the last byte's valid cycle.
  - A byte arriving in the same cycle as expiry wins: the counter clears and the byte is processed.
- Words already written before an error stay in memory. No rollback.
- mem_wr_addr and mem_wr_data hold their last values when mem_wr_en=0.
- Reset in any state immediately returns the block to the reset condition. The next byte starts a new frame.

Test Plan:
1. Normal load: bytes 02 00 00 00, 78 56 34 12, EF BE AD DE, then 4C → writes (BASE+0, 0x12345678) and (BASE+4, 0xDEADBEEF), each mem_wr_en one cycle after its 4th byte. load_done pulses the cycle after 0x4C; cpu_hold falls with it; load_err never asserts.
2. Bad checksum: same frame ending with 4D → both writes occur. load_err pulses, err_sticky=1, no load_done, cpu_hold=0.
3. Empty frame: 00 00 00 00 00 → load_done, no mem_wr_en. Then 00 00 00 00 01 → load_err.
4. Length overflow: N=MAX_WORDS+1 (01 04 00 00 for MAX_WORDS=1024) → load_err after the 4th byte. No writes; the next frame loads normally.
5. Timeout (TIMEOUT_CYCLES=100 in the bench): 3 length bytes, then silence → load_err exactly 100 cycles after the 3rd byte. Also send a byte exactly at the expiry cycle → no error. A following good frame clears err_sticky on its first byte.
6. Stress and reset:
   - Frame of N=3 with valid high on every consecutive cycle → 3 correct writes and load_done.
   - Assert reset mid-DATA → all outputs 0 next cycle; a fresh frame afterwards writes from BASE+0.
